// File: rtl/soc_shared_slave_arbiter.sv
// Round-robin Avalon-MM arbiter sharing one fixed-latency slave between NUM_MASTERS data masters.
// Optional atomic-lock support is enabled by defining ARB_LOCK_EN (adds the m_lock port).
module soc_shared_slave_arbiter #(
    parameter int unsigned NUM_MASTERS  = 2,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
`ifdef ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]        m_lock,
`endif
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic [ADDR_W-1:0]             s_address,
    output logic                          s_read,
    output logic                          s_write,
    output logic [DATA_W-1:0]             s_writedata,
    input  logic [DATA_W-1:0]             s_readdata
);

    localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned CW = $clog2(READ_LATENCY + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;

    logic [1:0]             state, state_d;
    logic [GW-1:0]          grant, grant_d;
    logic [GW-1:0]          last_grant, last_grant_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic [NUM_MASTERS-1:0] wait_d;
    logic [NUM_MASTERS-1:0] rdv_d;
    logic [DATA_W-1:0]      rdata_d;
    logic [ADDR_W-1:0]      s_address_d;
    logic [DATA_W-1:0]      s_writedata_d;
    logic                   s_read_d, s_write_d;
    logic [NUM_MASTERS-1:0] req;
    logic [GW-1:0]          sel;
    logic                   found;
`ifdef ARB_LOCK_EN
    logic                   lock_q, lock_d;
`endif

    assign req = m_read | m_write;

    // Rotating priority search starting just after the last granted master.
    always_comb begin
        int idx;
        idx   = 0;
        sel   = last_grant;
        found = 1'b0;
        for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
            idx = int'(last_grant) + k;
            if (idx >= int'(NUM_MASTERS)) begin
                idx = idx - int'(NUM_MASTERS);
            end
            if (!found && req[GW'(idx)]) begin
                sel   = GW'(idx);
                found = 1'b1;
            end
        end
`ifdef ARB_LOCK_EN
        if (lock_q && req[last_grant]) begin
            sel = last_grant;
        end
`endif
    end

    // Next-state and next-output logic; every output is the registered image of its _d value.
    always_comb begin
        state_d       = state;
        grant_d       = grant;
        last_grant_d  = last_grant;
        cnt_d         = cnt;
        wait_d        = '1;
        rdv_d         = '0;
        rdata_d       = m_readdata;
        s_address_d   = s_address;
        s_writedata_d = s_writedata;
        s_read_d      = 1'b0;
        s_write_d     = 1'b0;
`ifdef ARB_LOCK_EN
        lock_d        = lock_q;
`endif
        case (state)
            IDLE: begin
`ifdef ARB_LOCK_EN
                if (lock_q && !req[last_grant]) begin
                    lock_d = 1'b0;
                end
`endif
                if (|req) begin
                    state_d       = ISSUE;
                    grant_d       = sel;
                    wait_d[sel]   = 1'b0;
                    s_address_d   = m_address[ADDR_W*int'(sel) +: ADDR_W];
                    s_writedata_d = m_writedata[DATA_W*int'(sel) +: DATA_W];
                    s_read_d      = m_read[sel];
                    // Simultaneous read and write is treated as a read.
                    s_write_d     = m_write[sel] & ~m_read[sel];
                end
            end
            ISSUE: begin
                last_grant_d = grant;
`ifdef ARB_LOCK_EN
                lock_d       = m_lock[grant];
`endif
                if (s_read) begin
                    state_d = RDWAIT;
                    cnt_d   = CW'(READ_LATENCY);
                end else begin
                    state_d = IDLE;
                end
            end
            RDWAIT: begin
                cnt_d = cnt - CW'(1);
                // Counter reaches zero on this edge: slave data is valid now.
                if (cnt == CW'(1)) begin
                    rdata_d      = s_readdata;
                    rdv_d[grant] = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            grant           <= '0;
            last_grant      <= GW'(NUM_MASTERS - 1);
            cnt             <= '0;
            m_waitrequest   <= '1;
            m_readdatavalid <= '0;
            m_readdata      <= '0;
            s_address       <= '0;
            s_writedata     <= '0;
            s_read          <= 1'b0;
            s_write         <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_q          <= 1'b0;
`endif
        end else begin
            state           <= state_d;
            grant           <= grant_d;
            last_grant      <= last_grant_d;
            cnt             <= cnt_d;
            m_waitrequest   <= wait_d;
            m_readdatavalid <= rdv_d;
            m_readdata      <= rdata_d;
            s_address       <= s_address_d;
            s_writedata     <= s_writedata_d;
            s_read          <= s_read_d;
            s_write         <= s_write_d;
`ifdef ARB_LOCK_EN
            lock_q          <= lock_d;
`endif
        end
    end

endmodule

// File: tb/tb_soc_shared_slave_arbiter.sv
// Directed bench for soc_shared_slave_arbiter: 2 masters, slave read latency 2.
// Lock sequence is exercised only when ARB_LOCK_EN is defined.
module tb_soc_shared_slave_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NM*AW-1:0] m_address = '0;
    logic [NM-1:0]    m_read = '0;
    logic [NM-1:0]    m_write = '0;
    logic [NM*DW-1:0] m_writedata = '0;
    logic [NM-1:0]    m_lock = '0;
    logic [NM-1:0]    m_waitrequest;
    logic [DW-1:0]    m_readdata;
    logic [NM-1:0]    m_readdatavalid;
    logic [AW-1:0]    s_address;
    logic             s_read;
    logic             s_write;
    logic [DW-1:0]    s_writedata;
    logic [DW-1:0]    s_readdata;

    int n_cmp = 0;
    int n_err = 0;

    soc_shared_slave_arbiter #(
        .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)
    ) dut (
        .clock(clock), .reset(reset),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
`ifdef ARB_LOCK_EN
        .m_lock(m_lock),
`endif
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_readdata(s_readdata)
    );

    always #5 clock = ~clock;

    // Fixed-latency slave: data is valid only in the cycle RL cycles after the read strobe.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] rd_addr_q = '0;
    logic [RL-1:0] v_pipe = '0;
    always @(posedge clock) begin
        if (s_read) rd_addr_q <= s_address;
        v_pipe <= {v_pipe[RL-2:0], s_read};
    end
    assign s_readdata = v_pipe[RL-1] ? mem[rd_addr_q] : 32'hBAD0_BAD0;

    typedef struct {
        logic [1:0]  rd, wr;
        logic [9:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  ew;
        logic        esr, esw;
        logic [9:0]  ea;
        logic [31:0] ewd;
        logic [1:0]  erdv;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Compares one cycle of outputs; address/data only where the expected strobe makes them meaningful.
    task automatic check_cycle(input string name, input logic [1:0] ew, input logic esr, input logic esw,
                               input logic [9:0] ea, input logic [31:0] ewd,
                               input logic [1:0] erdv, input logic [31:0] erd);
        logic [79:0] act, exp;
        act = {m_waitrequest, s_read, s_write, m_readdatavalid,
               (esr | esw) ? s_address : 10'h0, esw ? s_writedata : 32'h0,
               (|erdv) ? m_readdata : 32'h0};
        exp = {ew, esr, esw, erdv, (esr | esw) ? ea : 10'h0, esw ? ewd : 32'h0,
               (|erdv) ? erd : 32'h0};
        chk(name, act, exp);
    endtask

    task automatic set_in(input logic [1:0] rd, input logic [1:0] wr, input logic [9:0] a0,
                          input logic [9:0] a1, input logic [31:0] d0, input logic [31:0] d1);
        m_read      = rd;
        m_write     = wr;
        m_address   = {a1, a0};
        m_writedata = {d1, d0};
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        mem[10'h040] = 32'h63BA_7E2C;
        mem[10'h011] = 32'h1234_5678;

        //                rd     wr     a0      a1      d0            d1            ew     sr    sw    ea      ewd           rdv    rdata
        tbl[0]  = '{2'b00, 2'b01, 10'h005, 10'h000, 32'hDEADBEEF, 32'h0,        2'b10, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 2'b00, 32'h0};
        tbl[1]  = '{2'b00, 2'b01, 10'h005, 10'h000, 32'hDEADBEEF, 32'h0,        2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b00, 32'h0};
        tbl[2]  = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b00, 32'h0};
        tbl[3]  = '{2'b10, 2'b00, 10'h000, 10'h040, 32'h0,        32'h0,        2'b01, 1'b1, 1'b0, 10'h040, 32'h0,        2'b00, 32'h0};
        tbl[4]  = '{2'b10, 2'b00, 10'h000, 10'h040, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b00, 32'h0};
        tbl[5]  = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b00, 32'h0};
        tbl[6]  = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b10, 32'h63BA7E2C};
        tbl[7]  = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b00, 32'h0};
        tbl[8]  = '{2'b01, 2'b01, 10'h011, 10'h000, 32'h5555AAAA, 32'h0,        2'b10, 1'b1, 1'b0, 10'h011, 32'h0,        2'b00, 32'h0};
        tbl[9]  = '{2'b01, 2'b01, 10'h011, 10'h000, 32'h5555AAAA, 32'h0,        2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b00, 32'h0};
        tbl[10] = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b00, 32'h0};
        tbl[11] = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b01, 32'h12345678};
        tbl[12] = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b00, 32'h0};
        tbl[13] = '{2'b00, 2'b11, 10'h0A0, 10'h0B1, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b01, 1'b0, 1'b1, 10'h0B1, 32'hB1B1B1B1, 2'b00, 32'h0};
        tbl[14] = '{2'b00, 2'b11, 10'h0A0, 10'h0B1, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b00, 32'h0};
        tbl[15] = '{2'b00, 2'b01, 10'h0A0, 10'h0B1, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b10, 1'b0, 1'b1, 10'h0A0, 32'hA0A0A0A0, 2'b00, 32'h0};
        tbl[16] = '{2'b00, 2'b01, 10'h0A0, 10'h0B1, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b00, 32'h0};
        tbl[17] = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b11, 1'b0, 1'b0, 10'h000, 32'h0,        2'b00, 32'h0};

        // Reset values
        cycle();
        cycle();
        chk("rst_wait",  80'(m_waitrequest),   80'(2'b11));
        chk("rst_rdv",   80'(m_readdatavalid), 80'(2'b00));
        chk("rst_rdata", 80'(m_readdata),      80'(32'h0));
        chk("rst_strb",  80'({s_read, s_write}), 80'(2'b00));
        chk("rst_saddr", 80'(s_address),       80'(10'h0));
        chk("rst_swd",   80'(s_writedata),     80'(32'h0));
        reset = 1'b0;
        cycle();
        check_cycle("idle_noreq", 2'b11, 1'b0, 1'b0, 10'h0, 32'h0, 2'b00, 32'h0);

        // Cycle-by-cycle vector table
        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].rd, tbl[i].wr, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            cycle();
            check_cycle($sformatf("vec%0d", i), tbl[i].ew, tbl[i].esr, tbl[i].esw, tbl[i].ea,
                        tbl[i].ewd, tbl[i].erdv, tbl[i].erd);
        end

        // Continuous writes from both masters after reset: strict 0,1,0,1 rotation
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        set_in(2'b00, 2'b11, 10'h0A0, 10'h0B1, 32'hA0A0A0A0, 32'hB1B1B1B1);
        for (int c = 0; c < 8; c++) begin
            cycle();
            case (c % 4)
                0: check_cycle($sformatf("rot%0d", c), 2'b10, 1'b0, 1'b1, 10'h0A0, 32'hA0A0A0A0, 2'b00, 32'h0);
                2: check_cycle($sformatf("rot%0d", c), 2'b01, 1'b0, 1'b1, 10'h0B1, 32'hB1B1B1B1, 2'b00, 32'h0);
                default: check_cycle($sformatf("rot%0d", c), 2'b11, 1'b0, 1'b0, 10'h0, 32'h0, 2'b00, 32'h0);
            endcase
        end
        set_in(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        cycle();

        // Reset during RDWAIT discards the read and restores master-0 priority
        set_in(2'b01, 2'b00, 10'h011, 10'h0, 32'h0, 32'h0);
        cycle();
        check_cycle("rr_issue", 2'b10, 1'b1, 1'b0, 10'h011, 32'h0, 2'b00, 32'h0);
        cycle();
        set_in(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        check_cycle("rr_wait", 2'b11, 1'b0, 1'b0, 10'h0, 32'h0, 2'b00, 32'h0);
        reset = 1'b1;
        #1;
        check_cycle("rr_async", 2'b11, 1'b0, 1'b0, 10'h0, 32'h0, 2'b00, 32'h0);
        cycle();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check_cycle($sformatf("rr_norv%0d", c), 2'b11, 1'b0, 1'b0, 10'h0, 32'h0, 2'b00, 32'h0);
        end
        set_in(2'b00, 2'b11, 10'h0A0, 10'h0B1, 32'hA0A0A0A0, 32'hB1B1B1B1);
        cycle();
        check_cycle("rr_m0first", 2'b10, 1'b0, 1'b1, 10'h0A0, 32'hA0A0A0A0, 2'b00, 32'h0);
        cycle();
        set_in(2'b00, 2'b10, 10'h0A0, 10'h0B1, 32'hA0A0A0A0, 32'hB1B1B1B1);
        cycle();
        check_cycle("rr_m1next", 2'b01, 1'b0, 1'b1, 10'h0B1, 32'hB1B1B1B1, 2'b00, 32'h0);
        cycle();
        // Lone master-0 write leaves master 1 next in rotation
        set_in(2'b00, 2'b01, 10'h0A0, 10'h0, 32'hA0A0A0A0, 32'h0);
        cycle();
        check_cycle("lone_m0", 2'b10, 1'b0, 1'b1, 10'h0A0, 32'hA0A0A0A0, 2'b00, 32'h0);
        cycle();
        set_in(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        cycle();

`ifdef ARB_LOCK_EN
        // Master 1 locked read then unlocked write run back-to-back ahead of master 0
        set_in(2'b10, 2'b01, 10'h0C0, 10'h040, 32'hC0C0C0C0, 32'h0);
        m_lock = 2'b10;
        cycle();
        check_cycle("lk_rd", 2'b01, 1'b1, 1'b0, 10'h040, 32'h0, 2'b00, 32'h0);
        cycle();
        set_in(2'b00, 2'b11, 10'h0C0, 10'h0D1, 32'hC0C0C0C0, 32'hD1D1D1D1);
        m_lock = 2'b00;
        cycle();
        cycle();
        check_cycle("lk_rdv", 2'b11, 1'b0, 1'b0, 10'h0, 32'h0, 2'b10, 32'h63BA7E2C);
        cycle();
        check_cycle("lk_wr_m1", 2'b01, 1'b0, 1'b1, 10'h0D1, 32'hD1D1D1D1, 2'b00, 32'h0);
        cycle();
        set_in(2'b00, 2'b01, 10'h0C0, 10'h0, 32'hC0C0C0C0, 32'h0);
        cycle();
        check_cycle("lk_m0", 2'b10, 1'b0, 1'b1, 10'h0C0, 32'hC0C0C0C0, 2'b00, 32'h0);
        cycle();
        set_in(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
